clk_rate_gen: RTL and testbench

CLK_RATE_GEN -- requirements
Module: clk_rate_gen

---
 rtl/clk_rate_gen_pkg.sv | 15 +
 rtl/clk_rate_gen_if.sv | 22 ++
 rtl/clk_rate_gen_edge_detect.sv | 26 ++
 rtl/clk_rate_gen.sv | 158 +++++++++++++++
 tb/tb_clk_rate_gen.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_rate_gen_pkg.sv
// Shared state encoding and default half-period constants for clk_rate_gen.
package clk_rate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int unsigned DIV0_DEF = 10000;
  localparam int unsigned DIV1_DEF = 100000;
  localparam int unsigned DIV2_DEF = 1000000;
  localparam int unsigned DIV3_DEF = 10000000;

endpackage

// File: rtl/clk_rate_gen_if.sv
// Control/status bundle for clk_rate_gen: rate and run controls in, divided clock and status out.
interface clk_rate_gen_if;

  logic        Go;
  logic [1:0]  Hz;
  logic        step;
  logic        clk_N;
  logic        tick;
  logic        busy;
  logic [31:0] period_cnt;

  modport master (
    output Go, Hz, step,
    input  clk_N, tick, busy, period_cnt
  );

  modport slave (
    input  Go, Hz, step,
    output clk_N, tick, busy, period_cnt
  );

endinterface

// File: rtl/clk_rate_gen_edge_detect.sv
// Registered rising-edge detector: rise is high for the cycle where d is 1 but was 0 at the previous edge.
module edge_detect (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/clk_rate_gen.sv
// Programmable clock divider with IDLE/HIGH/LOW phases, rise tick and rise counter.
// Optional single-step button support is built when CLK_STEP_MODE_EN is defined.
module clk_rate_gen
  import clk_rate_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DIV0  = DIV0_DEF,
  parameter int unsigned DIV1  = DIV1_DEF,
  parameter int unsigned DIV2  = DIV2_DEF,
  parameter int unsigned DIV3  = DIV3_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        Go,
  input  logic [1:0]  Hz,
  input  logic        step,
  output logic        clk_N,
  output logic        tick,
  output logic        busy,
  output logic [31:0] period_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic               clk_n_q, clk_n_d;
  logic               tick_q, tick_d;
  logic [31:0]        period_cnt_q, period_cnt_d;
  logic               step_pend;
  logic               enter_high;
  logic               start;
  logic               phase_last;

  // A zero divisor would never match cnt == H-1, so it is promoted to 1.
  function automatic logic [CNT_W-1:0] half_of(input logic [1:0] sel);
    logic [CNT_W-1:0] h;
    unique case (sel)
      2'd0:    h = CNT_W'(DIV0);
      2'd1:    h = CNT_W'(DIV1);
      2'd2:    h = CNT_W'(DIV2);
      default: h = CNT_W'(DIV3);
    endcase
    return (h == '0) ? CNT_W'(1) : h;
  endfunction

`ifdef CLK_STEP_MODE_EN
  logic step_rise;
  logic step_pend_q, step_pend_d;

  edge_detect u_step_edge (
    .clk  (clk),
    .clr  (clr),
    .d    (step),
    .rise (step_rise)
  );

  // A rise coinciding with the consuming edge re-arms the request; otherwise rises merge.
  always_comb begin
    step_pend_d = step_pend_q | step_rise;
    if (enter_high && !Go) begin
      step_pend_d = step_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      step_pend_q <= 1'b0;
    end else begin
      step_pend_q <= step_pend_d;
    end
  end

  assign step_pend = step_pend_q;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_pend   = 1'b0;
`endif

  assign start      = Go | step_pend;
  assign phase_last = (cnt_q == (h_q - CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    h_d          = h_q;
    clk_n_d      = clk_n_q;
    tick_d       = 1'b0;
    period_cnt_d = period_cnt_q;
    enter_high   = 1'b0;

    unique case (state_q)
      IDLE: begin
        enter_high = start;
      end
      HIGH: begin
        if (phase_last) begin
          state_d = LOW;
          cnt_d   = '0;
          clk_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOW: begin
        if (phase_last) begin
          cnt_d = '0;
          if (start) begin
            enter_high = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_n_d = 1'b0;
      end
    endcase

    // Every entry to HIGH relatches H, so Hz changes only apply at period boundaries.
    if (enter_high) begin
      state_d      = HIGH;
      cnt_d        = '0;
      clk_n_d      = 1'b1;
      tick_d       = 1'b1;
      h_d          = half_of(Hz);
      period_cnt_d = period_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      h_q          <= half_of(2'd0);
      clk_n_q      <= 1'b0;
      tick_q       <= 1'b0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      h_q          <= h_d;
      clk_n_q      <= clk_n_d;
      tick_q       <= tick_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign clk_N      = clk_n_q;
  assign tick       = tick_q;
  assign busy       = (state_q != IDLE);
  assign period_cnt = period_cnt_q;

endmodule

// File: tb/tb_clk_rate_gen.sv
// Scoreboard bench for clk_rate_gen: a period-position reference model queues expected outputs per edge.
module tb_clk_rate_gen;

  localparam int unsigned T_DIV0 = 2;
  localparam int unsigned T_DIV1 = 3;
  localparam int unsigned T_DIV2 = 1;
  localparam int unsigned T_DIV3 = 0;

  typedef struct packed {
    logic        clk_n;
    logic        tick;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  clk_rate_gen_if bus ();

  clk_rate_gen #(
    .CNT_W (32),
    .DIV0  (T_DIV0),
    .DIV1  (T_DIV1),
    .DIV2  (T_DIV2),
    .DIV3  (T_DIV3)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .Go         (bus.Go),
    .Hz         (bus.Hz),
    .step       (bus.step),
    .clk_N      (bus.clk_N),
    .tick       (bus.tick),
    .busy       (bus.busy),
    .period_cnt (bus.period_cnt)
  );

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  // Reference model: position within the current period instead of explicit phases.
  bit          m_run;
  int unsigned m_pos;
  int unsigned m_h;
  logic [31:0] m_cnt;
  bit          m_pend;
  bit          m_prev_step;

  function automatic int unsigned half_for(input logic [1:0] hz);
    int unsigned v;
    case (hz)
      2'd0:    v = T_DIV0;
      2'd1:    v = T_DIV1;
      2'd2:    v = T_DIV2;
      default: v = T_DIV3;
    endcase
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_edge(input bit c, input bit go, input logic [1:0] hz, input bit st);
    bit   rise;
    bit   rising;
    exp_t e;
    rising = 1'b0;
    if (c) begin
      m_run       = 1'b0;
      m_pos       = 0;
      m_h         = half_for(2'd0);
      m_cnt       = '0;
      m_pend      = 1'b0;
      m_prev_step = 1'b0;
    end else begin
`ifdef CLK_STEP_MODE_EN
      rise = st && !m_prev_step;
`else
      rise = 1'b0;
`endif
      m_prev_step = st;
      if (!m_run) begin
        rising = go || m_pend;
      end else begin
        m_pos++;
        if (m_pos == 2 * m_h) begin
          if (go || m_pend) begin
            rising = 1'b1;
          end else begin
            m_run = 1'b0;
            m_pos = 0;
          end
        end
      end
      if (rising && !go) m_pend = rise;
      else               m_pend = m_pend | rise;
      if (rising) begin
        m_run = 1'b1;
        m_pos = 0;
        m_h   = half_for(hz);
        m_cnt = m_cnt + 32'd1;
      end
    end
    e.clk_n = m_run && (m_pos < m_h);
    e.tick  = rising;
    e.busy  = m_run;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit c, input bit go, input logic [1:0] hz, input bit st);
    clr     = c;
    bus.Go  = go;
    bus.Hz  = hz;
    bus.step = st;
    @(posedge clk);
    model_edge(c, go, hz, st);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("clk_N",      {31'd0, bus.clk_N}, {31'd0, e.clk_n});
      chk("tick",       {31'd0, bus.tick},  {31'd0, e.tick});
      chk("busy",       {31'd0, bus.busy},  {31'd0, e.busy});
      chk("period_cnt", bus.period_cnt,     e.cnt);
    end
  end

  initial begin
    bit go_r;
    bit st_r;
    clr      = 1'b1;
    bus.Go   = 1'b0;
    bus.Hz   = 2'd0;
    bus.step = 1'b0;
    @(negedge clk);

    repeat (3) cycle(1, 0, 2'd0, 0);

    // Free run at H=2: rise on the first edge, period 4.
    repeat (20) cycle(0, 1, 2'd0, 0);
    repeat (8)  cycle(0, 0, 2'd0, 0);

    // Hz changed mid-HIGH: current period keeps H=2, next uses H=3.
    cycle(0, 1, 2'd0, 0);
    repeat (12) cycle(0, 1, 2'd1, 0);
    repeat (10) cycle(0, 0, 2'd1, 0);

    // Go dropped on the first HIGH cycle with H=3: period completes, then idle.
    cycle(1, 0, 2'd1, 0);
    cycle(0, 1, 2'd1, 0);
    repeat (10) cycle(0, 0, 2'd1, 0);

    // Abort by clr while HIGH.
    cycle(0, 1, 2'd1, 0);
    cycle(0, 1, 2'd1, 0);
    cycle(1, 1, 2'd1, 0);
    repeat (3) cycle(0, 0, 2'd1, 0);

    // Step requests with Go low: three rises inside one H=2 period.
    cycle(0, 0, 2'd0, 1);
    cycle(0, 0, 2'd0, 0);
    cycle(0, 0, 2'd0, 1);
    cycle(0, 0, 2'd0, 0);
    cycle(0, 0, 2'd0, 1);
    repeat (12) cycle(0, 0, 2'd0, 0);

    // Counter wrap from all-ones.
    force dut.period_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    cycle(0, 0, 2'd0, 0);
    release dut.period_cnt_q;
    cycle(0, 0, 2'd0, 0);
    cycle(0, 1, 2'd2, 0);
    repeat (4) cycle(0, 0, 2'd2, 0);

    // Randomized traffic with bursty Go/step levels and rare clr.
    go_r = 1'b0;
    st_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) go_r = ~go_r;
      if ($urandom_range(0, 3) == 0) st_r = ~st_r;
      cycle(($urandom_range(0, 63) == 0), go_r, 2'($urandom_range(0, 3)), st_r);
    end
    repeat (20) cycle(0, 0, 2'd0, 0);

    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
